// File: rtl/wb_ram_arbiter_pkg.sv
// ============================================================
// Module : wb_ram_arbiter_pkg
// Shared state encoding, CTI codes and master indices.
// Rev    : 1.0
// ============================================================
`default_nettype none

package wb_ram_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] c_CTI_INCR    = 3'b010;
  localparam logic [2:0] c_CTI_EOB     = 3'b111;

  localparam int c_DBG    = 0;
  localparam int c_OR1K_D = 1;
  localparam int c_OR1K_I = 2;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================
// Module : rr_arbiter
// One-hot round-robin pick: first requester strictly after last.
// Rev    : 1.0
// ============================================================
`default_nettype none

module rr_arbiter #(
  parameter int NM = 3,
  parameter int LW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] grant
);

  logic [LW:0]   w_sh;
  logic [NM-1:0] w_rot;
  logic [NM-1:0] w_iso;

  // Rotate so index last+1 lands at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    w_sh  = {1'b0, last} + (LW+1)'(1);
    w_rot = NM'({req, req} >> w_sh);
    w_iso = w_rot & (~w_rot + NM'(1));
    grant = NM'(({w_iso, w_iso} << w_sh) >> NM);
  end

endmodule

`default_nettype wire

// File: rtl/wb_ram_arbiter.sv
// ============================================================
// Module : wb_ram_arbiter
// Round-robin Wishbone arbiter sharing one RAM slave among NM masters.
// Rev    : 1.0
// ============================================================
`default_nettype none

module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM*2-1:0]  m_bte_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM-1:0]    m_rty_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic [2:0]       s_cti_o,
  output logic [1:0]       s_bte_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [NM-1:0]    grant_o
);

  localparam int LW = idx_w(NM);
  localparam int CW = idx_w(TIMEOUT + 1);
  localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

  state_t        r_state, w_state_nxt;
  logic [NM-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0] r_last,  w_last_nxt;
  logic [CW-1:0] r_wdog,  w_wdog_nxt;

  logic [NM-1:0] w_win;
  logic [LW-1:0] w_win_idx;
  logic          w_cyc_sel;
  logic          w_stb_sel;
  logic          w_resp;
  logic          w_timeout;

  rr_arbiter #(
    .NM (NM),
    .LW (LW)
  ) u_rr (
    .req   (m_cyc_i),
    .last  (r_last),
    .grant (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NM; i++)
      if (w_win[i]) w_win_idx = LW'(i);
  end

  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_timeout = (r_state == BUSY) && (r_wdog == c_timeout);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LW'(NM - 1);
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_wdog_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (|m_cyc_i) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_win;
          w_last_nxt  = w_win_idx;
        end
      end
      BUSY: begin
        // Ownership ends only when the owner itself drops cyc.
        if (!w_cyc_sel) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end else if (!w_timeout && !w_resp && w_stb_sel) begin
          w_wdog_nxt = r_wdog + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // grant is zero while idle, so every slave-side field falls to zero then.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    s_we_o    = 1'b0;
    w_cyc_sel = 1'b0;
    w_stb_sel = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (r_grant[i]) begin
        s_adr_o   = m_adr_i[i*AW +: AW];
        s_dat_o   = m_dat_i[i*DW +: DW];
        s_sel_o   = m_sel_i[i*4 +: 4];
        s_cti_o   = m_cti_i[i*3 +: 3];
        s_bte_o   = m_bte_i[i*2 +: 2];
        s_we_o    = m_we_i[i];
        w_cyc_sel = m_cyc_i[i];
        w_stb_sel = m_stb_i[i];
      end
    end
    s_cyc_o = w_cyc_sel;
    s_stb_o = w_stb_sel & ~w_timeout;
  end

  assign m_dat_o = s_dat_i;
  assign m_ack_o = r_grant & {NM{s_ack_i}};
  assign m_err_o = r_grant & {NM{s_err_i | w_timeout}};
  assign m_rty_o = r_grant & {NM{s_rty_i}};
  assign grant_o = r_grant;

endmodule

`default_nettype wire
